// File: rtl/rom_arb_pkg.sv
// rom_arb_pkg: shared types and constants for the ROM port arbiter.
//   - arb_state_e : arbiter FSM states
//   - req_id_e    : identifies which CPU read port holds the grant
//   - MEM_LAT_MIN / MEM_LAT_MAX : supported memory read latency range
//   - other_cpu() : returns the opposite CPU (round-robin pointer update)
package rom_arb_pkg;

  localparam int MEM_LAT_MIN = 1;
  localparam int MEM_LAT_MAX = 3;

  // Wait counter width; must hold MEM_LAT_MAX-1.
  localparam int CNT_W = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2,
    ST_RESP  = 2'd3
  } arb_state_e;

  typedef enum logic {
    CPU0 = 1'b0,
    CPU1 = 1'b1
  } req_id_e;

  function automatic req_id_e other_cpu(input req_id_e id);
    return (id == CPU0) ? CPU1 : CPU0;
  endfunction

endpackage

// File: rtl/rom_port_arb.sv
// rom_port_arb: shares one ROM/RAM port between a download loader (writes)
// and two CPU read ports.
//
// Ports
//   MCLK, RESET          : clock and synchronous active-high reset
//   LD_EN                : loader download active, blocks new CPU grants
//   LD_WR, LD_AD, LD_DT  : single-cycle loader write strobe, address, data
//   C0_REQ/C1_REQ        : CPU read requests, held until ACK
//   C0_AD/C1_AD          : CPU read addresses
//   C0_DT/C1_DT          : read data, held until the next ACK on that port
//   C0_ACK/C1_ACK        : one-cycle completion pulses
//   MEM_AD, MEM_WD, MEM_WE : registered shared memory address/data/write enable
//   MEM_RD               : memory read data, valid MEM_LAT cycles after MEM_AD
//   LD_OVF               : sticky flag, a loader write was dropped
//
// Loader writes always win over CPU reads. A write strobe that finds the
// holding register full (and not draining in that same cycle) is dropped.
module rom_port_arb
  import rom_arb_pkg::*;
#(
  parameter int AW      = 16,
  parameter int MEM_LAT = 1   // legal 1..3, out-of-range values are clamped
) (
  input  logic          MCLK,
  input  logic          RESET,
  input  logic          LD_EN,
  input  logic          LD_WR,
  input  logic [AW-1:0] LD_AD,
  input  logic [7:0]    LD_DT,
  input  logic          C0_REQ,
  input  logic [AW-1:0] C0_AD,
  input  logic          C1_REQ,
  input  logic [AW-1:0] C1_AD,
  output logic [7:0]    C0_DT,
  output logic          C0_ACK,
  output logic [7:0]    C1_DT,
  output logic          C1_ACK,
  output logic [AW-1:0] MEM_AD,
  output logic [7:0]    MEM_WD,
  output logic          MEM_WE,
  input  logic [7:0]    MEM_RD,
  output logic          LD_OVF
);

  localparam int LAT_EFF = (MEM_LAT < MEM_LAT_MIN) ? MEM_LAT_MIN :
                           (MEM_LAT > MEM_LAT_MAX) ? MEM_LAT_MAX : MEM_LAT;
  localparam logic [CNT_W-1:0] LAT_LAST = CNT_W'(LAT_EFF - 1);

  arb_state_e      state_q,  state_d;
  req_id_e         ptr_q,    ptr_d;
  req_id_e         gnt_q,    gnt_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;

  logic            hold_v_q,  hold_v_d;
  logic [AW-1:0]   hold_ad_q, hold_ad_d;
  logic [7:0]      hold_dt_q, hold_dt_d;
  logic            ovf_q,     ovf_d;

  logic [AW-1:0]   mem_ad_q,  mem_ad_d;
  logic [7:0]      mem_wd_q,  mem_wd_d;
  logic            mem_we_q,  mem_we_d;

  logic [7:0]      c0_dt_q,   c0_dt_d;
  logic [7:0]      c1_dt_q,   c1_dt_d;
  logic            c0_ack_q,  c0_ack_d;
  logic            c1_ack_q,  c1_ack_d;

  // A port that is being acknowledged this cycle still shows REQ high;
  // masking it prevents serving the same request twice.
  logic    req0_ok, req1_ok;
  req_id_e pick;

  assign req0_ok = C0_REQ && !c0_ack_q;
  assign req1_ok = C1_REQ && !c1_ack_q;

  always_comb begin
    if (req0_ok && req1_ok) begin
      pick = ptr_q;
    end else if (req1_ok) begin
      pick = CPU1;
    end else begin
      pick = CPU0;
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    gnt_d     = gnt_q;
    cnt_d     = cnt_q;
    hold_v_d  = hold_v_q;
    hold_ad_d = hold_ad_q;
    hold_dt_d = hold_dt_q;
    ovf_d     = ovf_q;
    mem_ad_d  = mem_ad_q;
    mem_wd_d  = mem_wd_q;
    mem_we_d  = 1'b0;
    c0_dt_d   = c0_dt_q;
    c1_dt_d   = c1_dt_q;
    c0_ack_d  = 1'b0;
    c1_ack_d  = 1'b0;

    // Holding register: emptied by the WRITE cycle, refilled by any strobe
    // that finds it empty or draining.
    if (state_q == ST_WRITE) begin
      hold_v_d = 1'b0;
    end
    if (LD_WR) begin
      if (!hold_v_q || (state_q == ST_WRITE)) begin
        hold_v_d  = 1'b1;
        hold_ad_d = LD_AD;
        hold_dt_d = LD_DT;
      end else begin
        ovf_d = 1'b1;
      end
    end

    unique case (state_q)
      ST_IDLE: begin
        // A strobe arriving in IDLE with an empty holding register is
        // forwarded straight to the memory registers so the write appears
        // on the very next cycle.
        if (hold_v_q || LD_WR) begin
          state_d  = ST_WRITE;
          mem_we_d = 1'b1;
          mem_ad_d = hold_v_q ? hold_ad_q : LD_AD;
          mem_wd_d = hold_v_q ? hold_dt_q : LD_DT;
        end else if (!LD_EN && (req0_ok || req1_ok)) begin
          state_d  = ST_READ;
          gnt_d    = pick;
          ptr_d    = other_cpu(pick);
          cnt_d    = '0;
          mem_ad_d = (pick == CPU1) ? C1_AD : C0_AD;
        end
      end
      ST_WRITE: begin
        state_d = ST_IDLE;
      end
      ST_READ: begin
        if (cnt_q == LAT_LAST) begin
          cnt_d   = '0;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
        if (gnt_q == CPU1) begin
          c1_dt_d  = MEM_RD;
          c1_ack_d = 1'b1;
        end else begin
          c0_dt_d  = MEM_RD;
          c0_ack_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge MCLK) begin
    if (RESET) begin
      state_q   <= ST_IDLE;
      ptr_q     <= CPU0;
      gnt_q     <= CPU0;
      cnt_q     <= '0;
      hold_v_q  <= 1'b0;
      hold_ad_q <= '0;
      hold_dt_q <= '0;
      ovf_q     <= 1'b0;
      mem_ad_q  <= '0;
      mem_wd_q  <= '0;
      mem_we_q  <= 1'b0;
      c0_dt_q   <= '0;
      c1_dt_q   <= '0;
      c0_ack_q  <= 1'b0;
      c1_ack_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      gnt_q     <= gnt_d;
      cnt_q     <= cnt_d;
      hold_v_q  <= hold_v_d;
      hold_ad_q <= hold_ad_d;
      hold_dt_q <= hold_dt_d;
      ovf_q     <= ovf_d;
      mem_ad_q  <= mem_ad_d;
      mem_wd_q  <= mem_wd_d;
      mem_we_q  <= mem_we_d;
      c0_dt_q   <= c0_dt_d;
      c1_dt_q   <= c1_dt_d;
      c0_ack_q  <= c0_ack_d;
      c1_ack_q  <= c1_ack_d;
    end
  end

  assign MEM_AD = mem_ad_q;
  assign MEM_WD = mem_wd_q;
  assign MEM_WE = mem_we_q;
  assign C0_DT  = c0_dt_q;
  assign C1_DT  = c1_dt_q;
  assign C0_ACK = c0_ack_q;
  assign C1_ACK = c1_ack_q;
  assign LD_OVF = ovf_q;

endmodule

// File: tb/tb_rom_port_arb.sv
// Directed bench for rom_port_arb. Instance u_a uses MEM_LAT=1 and carries
// most of the sequence; instance u_b uses MEM_LAT=3 for the long-latency read.
// Each instance has its own memory model: unwritten bytes read as
// f(a) = a[7:0] ^ a[15:8] ^ 8'h83, written bytes read back what was written.
`timescale 1ns/1ps
module tb_rom_port_arb;

  logic        MCLK = 1'b0;
  logic        RESET;
  logic        mem_clr;

  logic        LD_EN, LD_WR;
  logic [15:0] LD_AD;
  logic [7:0]  LD_DT;
  logic        C0_REQ, C1_REQ;
  logic [15:0] C0_AD, C1_AD;
  logic [7:0]  C0_DT, C1_DT;
  logic        C0_ACK, C1_ACK;
  logic [15:0] MEM_AD;
  logic [7:0]  MEM_WD, MEM_RD;
  logic        MEM_WE, LD_OVF;

  logic        b_LD_EN, b_LD_WR;
  logic [15:0] b_LD_AD;
  logic [7:0]  b_LD_DT;
  logic        b_C0_REQ, b_C1_REQ;
  logic [15:0] b_C0_AD, b_C1_AD;
  logic [7:0]  b_C0_DT, b_C1_DT;
  logic        b_C0_ACK, b_C1_ACK;
  logic [15:0] b_MEM_AD;
  logic [7:0]  b_MEM_WD, b_MEM_RD;
  logic        b_MEM_WE, b_LD_OVF;

  int n_cmp = 0;
  int n_err = 0;
  int we_seen;

  always #5 MCLK = ~MCLK;

  rom_port_arb #(.AW(16), .MEM_LAT(1)) u_a (
    .MCLK(MCLK), .RESET(RESET), .LD_EN(LD_EN), .LD_WR(LD_WR),
    .LD_AD(LD_AD), .LD_DT(LD_DT), .C0_REQ(C0_REQ), .C0_AD(C0_AD),
    .C1_REQ(C1_REQ), .C1_AD(C1_AD), .C0_DT(C0_DT), .C0_ACK(C0_ACK),
    .C1_DT(C1_DT), .C1_ACK(C1_ACK), .MEM_AD(MEM_AD), .MEM_WD(MEM_WD),
    .MEM_WE(MEM_WE), .MEM_RD(MEM_RD), .LD_OVF(LD_OVF)
  );

  rom_port_arb #(.AW(16), .MEM_LAT(3)) u_b (
    .MCLK(MCLK), .RESET(RESET), .LD_EN(b_LD_EN), .LD_WR(b_LD_WR),
    .LD_AD(b_LD_AD), .LD_DT(b_LD_DT), .C0_REQ(b_C0_REQ), .C0_AD(b_C0_AD),
    .C1_REQ(b_C1_REQ), .C1_AD(b_C1_AD), .C0_DT(b_C0_DT), .C0_ACK(b_C0_ACK),
    .C1_DT(b_C1_DT), .C1_ACK(b_C1_ACK), .MEM_AD(b_MEM_AD), .MEM_WD(b_MEM_WD),
    .MEM_WE(b_MEM_WE), .MEM_RD(b_MEM_RD), .LD_OVF(b_LD_OVF)
  );

  // ---------------- memory models ----------------
  function automatic logic [7:0] rom_init(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h83;
  endfunction

  logic [7:0] a_arr [0:65535];
  logic       a_wv  [0:65535];
  logic [7:0] a_pipe [0:2];
  logic [7:0] b_pipe [0:2];

  always @(posedge MCLK) begin
    if (mem_clr) begin
      for (int i = 0; i < 65536; i++) a_wv[i] <= 1'b0;
    end else if (MEM_WE) begin
      a_arr[MEM_AD] <= MEM_WD;
      a_wv[MEM_AD]  <= 1'b1;
    end
    a_pipe[0] <= a_wv[MEM_AD] ? a_arr[MEM_AD] : rom_init(MEM_AD);
    a_pipe[1] <= a_pipe[0];
    a_pipe[2] <= a_pipe[1];
    b_pipe[0] <= rom_init(b_MEM_AD);
    b_pipe[1] <= b_pipe[0];
    b_pipe[2] <= b_pipe[1];
  end

  assign MEM_RD   = a_pipe[0];
  assign b_MEM_RD = b_pipe[2];

  // ---------------- helpers ----------------
  task automatic tick();
    @(posedge MCLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    RESET = 1'b1; mem_clr = 1'b1;
    LD_EN = 0; LD_WR = 0; LD_AD = '0; LD_DT = '0;
    C0_REQ = 0; C1_REQ = 0; C0_AD = '0; C1_AD = '0;
    b_LD_EN = 0; b_LD_WR = 0; b_LD_AD = '0; b_LD_DT = '0;
    b_C0_REQ = 0; b_C1_REQ = 0; b_C0_AD = '0; b_C1_AD = '0;
    tick(); tick();

    // ---- reset state ----
    chk("rst_mem_ad", 32'(MEM_AD), 32'h0);
    chk("rst_mem_wd", 32'(MEM_WD), 32'h0);
    chk("rst_mem_we", 32'(MEM_WE), 32'h0);
    chk("rst_c0_dt",  32'(C0_DT),  32'h0);
    chk("rst_c1_dt",  32'(C1_DT),  32'h0);
    chk("rst_c0_ack", 32'(C0_ACK), 32'h0);
    chk("rst_c1_ack", 32'(C1_ACK), 32'h0);
    chk("rst_ovf",    32'(LD_OVF), 32'h0);
    chk("rst_b_ad",   32'(b_MEM_AD), 32'h0);
    RESET = 1'b0; mem_clr = 1'b0;
    tick();

    // ---- single CPU0 read, latency t+3, no double service ----
    C0_AD = 16'h1234; C0_REQ = 1'b1;
    tick();
    chk("rd0_mem_ad_t1", 32'(MEM_AD), 32'h1234);
    chk("rd0_ack_t1", 32'(C0_ACK), 32'h0);
    tick();
    chk("rd0_ack_t2", 32'(C0_ACK), 32'h0);
    tick();
    chk("rd0_ack_t3", 32'(C0_ACK), 32'h1);
    chk("rd0_dt_t3",  32'(C0_DT),  32'hA5);
    chk("rd0_we_t3",  32'(MEM_WE), 32'h0);
    tick();
    chk("rd0_ack_t4", 32'(C0_ACK), 32'h0);
    C0_REQ = 1'b0;
    tick(); tick();
    chk("rd0_no_double", 32'(C0_ACK), 32'h0);
    chk("rd0_dt_hold",   32'(C0_DT),  32'hA5);

    // ---- both CPUs requesting continuously: alternate grants ----
    // Pointer now favours CPU1 (CPU0 was granted last).
    C0_AD = 16'h0001; C1_AD = 16'h0210;
    C0_REQ = 1'b1; C1_REQ = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      chk($sformatf("rr_c1_ack_k%0d", k), 32'(C1_ACK), 32'((k == 3) || (k == 9)));
      chk($sformatf("rr_c0_ack_k%0d", k), 32'(C0_ACK), 32'((k == 6) || (k == 12)));
      if (k == 3) chk("rr_c1_dt", 32'(C1_DT), 32'h91);
      if (k == 6) chk("rr_c0_dt", 32'(C0_DT), 32'h82);
    end
    C0_REQ = 1'b0; C1_REQ = 1'b0;
    tick();

    // ---- loader overflow while a read is in flight ----
    C0_AD = 16'h1234; C0_REQ = 1'b1;
    tick();                                   // READ
    LD_WR = 1'b1; LD_AD = 16'h0050; LD_DT = 8'h11;
    tick();                                   // RESP, holding full
    chk("ovf_first_ok", 32'(LD_OVF), 32'h0);
    LD_AD = 16'h0051; LD_DT = 8'h22;
    tick();                                   // IDLE, ACK
    LD_WR = 1'b0; C0_REQ = 1'b0;
    chk("ovf_set",    32'(LD_OVF), 32'h1);
    chk("ovf_ack",    32'(C0_ACK), 32'h1);
    chk("ovf_dt",     32'(C0_DT),  32'hA5);
    chk("ovf_we_idle", 32'(MEM_WE), 32'h0);
    tick();
    chk("ovf_we",     32'(MEM_WE), 32'h1);
    chk("ovf_we_ad",  32'(MEM_AD), 32'h0050);
    chk("ovf_we_wd",  32'(MEM_WD), 32'h11);
    tick();
    chk("ovf_we_off", 32'(MEM_WE), 32'h0);
    tick();
    chk("ovf_dropped", 32'(MEM_WE), 32'h0);
    chk("ovf_sticky",  32'(LD_OVF), 32'h1);

    // ---- reset mid-read, then re-issue ----
    C1_AD = 16'h4000; C1_REQ = 1'b1;
    tick();
    chk("rr_rst_mem_ad", 32'(MEM_AD), 32'h4000);
    RESET = 1'b1;
    tick();
    chk("rr_rst_ack1", 32'(C1_ACK), 32'h0);
    chk("rr_rst_ad",   32'(MEM_AD), 32'h0);
    chk("rr_rst_wd",   32'(MEM_WD), 32'h0);
    chk("rr_rst_dt0",  32'(C0_DT),  32'h0);
    chk("rr_rst_dt1",  32'(C1_DT),  32'h0);
    chk("rr_rst_ovf",  32'(LD_OVF), 32'h0);
    tick();
    chk("rr_rst_ack2", 32'(C1_ACK), 32'h0);
    RESET = 1'b0;
    tick();
    chk("rr_reissue_ad", 32'(MEM_AD), 32'h4000);
    chk("rr_reissue_ack1", 32'(C1_ACK), 32'h0);
    tick(); tick();
    chk("rr_reissue_ack", 32'(C1_ACK), 32'h1);
    chk("rr_reissue_dt",  32'(C1_DT),  32'hC3);
    C1_REQ = 1'b0;
    tick();

    // ---- loader download: 256 writes, CPU blocked ----
    LD_EN = 1'b1; C0_AD = 16'h0010; C0_REQ = 1'b1;
    tick();
    we_seen = 0;
    for (int i = 0; i < 256; i++) begin
      LD_WR = 1'b1; LD_AD = 16'(i); LD_DT = 8'(i) ^ 8'hC3;
      tick();
      LD_WR = 1'b0;
      if (MEM_WE === 1'b1) we_seen++;
      chk($sformatf("ld_we_%0d", i), 32'(MEM_WE), 32'h1);
      chk($sformatf("ld_ad_%0d", i), 32'(MEM_AD), 32'(i));
      chk($sformatf("ld_wd_%0d", i), 32'(MEM_WD), 32'(8'(i) ^ 8'hC3));
      tick();
      chk($sformatf("ld_we_off_%0d", i), 32'(MEM_WE), 32'h0);
      tick(); tick();
      chk($sformatf("ld_no_ack_%0d", i), 32'({C1_ACK, C0_ACK}), 32'h0);
    end
    chk("ld_we_count", 32'(we_seen), 32'd256);
    chk("ld_ovf_clear", 32'(LD_OVF), 32'h0);

    // Release the download: pending CPU0 read of a loaded byte is served.
    LD_EN = 1'b0;
    tick();
    chk("ld_rel_ad", 32'(MEM_AD), 32'h0010);
    tick();
    chk("ld_rel_ack_early", 32'(C0_ACK), 32'h0);
    tick();
    chk("ld_rel_ack", 32'(C0_ACK), 32'h1);
    chk("ld_rel_dt",  32'(C0_DT),  32'hD3);
    C0_REQ = 1'b0;
    tick();

    // ---- strobe coinciding with a draining WRITE is captured ----
    LD_WR = 1'b1; LD_AD = 16'h0300; LD_DT = 8'h77;
    tick();
    chk("drain_we1", 32'(MEM_WE), 32'h1);
    chk("drain_ad1", 32'(MEM_AD), 32'h0300);
    LD_AD = 16'h0301; LD_DT = 8'h88;
    tick();
    LD_WR = 1'b0;
    chk("drain_gap",  32'(MEM_WE), 32'h0);
    chk("drain_ovf",  32'(LD_OVF), 32'h0);
    tick();
    chk("drain_we2", 32'(MEM_WE), 32'h1);
    chk("drain_ad2", 32'(MEM_AD), 32'h0301);
    chk("drain_wd2", 32'(MEM_WD), 32'h88);
    tick();

    // ---- MEM_LAT=3 instance: CPU1 read ACK at t+5 ----
    b_C1_AD = 16'h00FF; b_C1_REQ = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      tick();
      if (k == 1) chk("lat3_ad", 32'(b_MEM_AD), 32'h00FF);
      chk($sformatf("lat3_ack_k%0d", k), 32'(b_C1_ACK), 32'(k == 5));
    end
    chk("lat3_dt", 32'(b_C1_DT), 32'h7C);
    b_C1_REQ = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
